regfile_port_arbiter: RTL and testbench

//  Shares the single write port and two registered read ports of the 32x32 register file between two requesters.

---
 rtl/regfile_port_arbiter_pkg.sv | 14 +
 rtl/rr_starve_cnt.sv | 30 +++
 rtl/regfile_port_arbiter.sv | 123 ++++++++++++
 tb/tb_regfile_port_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_port_arbiter_pkg.sv
// Shared widths, counter sizing and arbitration state encoding for the
// register-file port arbiter.
package regfile_port_arbiter_pkg;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int CNT_W = 4;   // holds MAX_WAIT up to 15

    typedef enum logic {
        ARB   = 1'b0,
        DLOCK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_starve_cnt.sv
// Counts consecutive contended core wins and flags when debug must be
// forced through.
module rr_starve_cnt #(
    parameter int MAX_WAIT = 4,
    parameter int CW       = regfile_port_arbiter_pkg::CNT_W
) (
    input  logic CLK,
    input  logic RST,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    logic [CW-1:0] wait_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs at the same edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wait_cnt <= '0;
        end else if (clr) begin
            wait_cnt <= '0;
        end else if (inc && (wait_cnt != '1)) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    assign at_max = (wait_cnt == CW'(MAX_WAIT));

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares the register-file write port and two registered read ports between
// the CPU core (c_*) and the debug monitor (d_*).
module regfile_port_arbiter #(
    parameter int AW       = regfile_port_arbiter_pkg::AW,
    parameter int DW       = regfile_port_arbiter_pkg::DW,
    parameter int MAX_WAIT = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_wa,
    input  logic [AW-1:0] c_ra1,
    input  logic [AW-1:0] c_ra2,
    input  logic [DW-1:0] c_wd,
    output logic          c_gnt,
    output logic          c_rvalid,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_wa,
    input  logic [AW-1:0] d_ra1,
    input  logic [AW-1:0] d_ra2,
    input  logic [DW-1:0] d_wd,
    input  logic          d_lock,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    output logic          RegW,
    output logic [AW-1:0] DR,
    output logic [AW-1:0] SR1,
    output logic [AW-1:0] SR2,
    output logic [DW-1:0] Reg_In,
    input  logic [DW-1:0] ReadReg1,
    input  logic [DW-1:0] ReadReg2
);

    import regfile_port_arbiter_pkg::*;

    arb_state_e state, state_nxt;
    logic       at_max;
    logic       arb_mode;

    always_ff @(posedge CLK) begin
        if (RST) state <= ARB;
        else     state <= state_nxt;
    end

    // Dropping d_lock releases the port in the same cycle, so that cycle is
    // arbitrated normally rather than as a locked one.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        c_gnt     = 1'b0;
        d_gnt     = 1'b0;
        state_nxt = state;
        arb_mode  = (state == ARB) || !d_lock;

        if (!RST) begin
            if (!arb_mode) begin
                d_gnt = d_req;
            end else if (c_req && d_req) begin
                d_gnt = at_max;
                c_gnt = !at_max;
            end else begin
                c_gnt = c_req;
                d_gnt = d_req;
            end
        end

        case (state)
            ARB:     if (d_gnt && d_lock) state_nxt = DLOCK;
            DLOCK:   if (!d_lock)         state_nxt = ARB;
            default:                      state_nxt = ARB;
        endcase
    end

    rr_starve_cnt #(
        .MAX_WAIT (MAX_WAIT),
        .CW       (CNT_W)
    ) u_starve (
        .CLK    (CLK),
        .RST    (RST),
        .inc    (c_gnt && d_req),
        .clr    (d_gnt || !d_req),
        .at_max (at_max)
    );

    // Writes to R0 are dropped; the reads of that grant still go out.
    always_comb begin
        RegW   = 1'b0;
        DR     = '0;
        SR1    = '0;
        SR2    = '0;
        Reg_In = '0;
        if (c_gnt) begin
            RegW   = c_we && (c_wa != '0);
            DR     = c_wa;
            SR1    = c_ra1;
            SR2    = c_ra2;
            Reg_In = c_wd;
        end else if (d_gnt) begin
            RegW   = d_we && (d_wa != '0);
            DR     = d_wa;
            SR1    = d_ra1;
            SR2    = d_ra2;
            Reg_In = d_wd;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            c_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
        end else begin
            c_rvalid <= c_gnt;
            d_rvalid <= d_gnt;
        end
    end

    assign rd1 = ReadReg1;
    assign rd2 = ReadReg2;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Self-checking bench for regfile_port_arbiter: vector table, directed
// corner sequences and random traffic against a behavioural model.
module tb_regfile_port_arbiter;

    localparam int AW       = 5;
    localparam int DW       = 32;
    localparam int MAX_WAIT = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          c_req, c_we, d_req, d_we, d_lock;
    logic [AW-1:0] c_wa, c_ra1, c_ra2, d_wa, d_ra1, d_ra2;
    logic [DW-1:0] c_wd, d_wd;
    logic          c_gnt, c_rvalid, d_gnt, d_rvalid, RegW;
    logic [AW-1:0] DR, SR1, SR2;
    logic [DW-1:0] rd1, rd2, Reg_In, ReadReg1, ReadReg2;

    always #5 CLK = ~CLK;

    regfile_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .CLK(CLK), .RST(RST),
        .c_req(c_req), .c_we(c_we), .c_wa(c_wa), .c_ra1(c_ra1), .c_ra2(c_ra2),
        .c_wd(c_wd), .c_gnt(c_gnt), .c_rvalid(c_rvalid),
        .d_req(d_req), .d_we(d_we), .d_wa(d_wa), .d_ra1(d_ra1), .d_ra2(d_ra2),
        .d_wd(d_wd), .d_lock(d_lock), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .rd1(rd1), .rd2(rd2), .RegW(RegW), .DR(DR), .SR1(SR1), .SR2(SR2),
        .Reg_In(Reg_In), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2)
    );

    // External 32x32 register file: registered reads see the pre-write value.
    logic [DW-1:0] rf [32];
    always @(posedge CLK) begin
        ReadReg1 <= rf[SR1];
        ReadReg2 <= rf[SR2];
        if (RegW) rf[DR] <= Reg_In;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: streak of contended core wins, lock flag, memory image.
    int            streak;
    bit            locked;
    logic [DW-1:0] mem_m [32];
    bit            pc, pd;
    logic [DW-1:0] p1, p2;
    logic          e_c, e_d, e_regw;
    logic [AW-1:0] e_dr, e_sr1, e_sr2;
    logic [DW-1:0] e_in;
    logic          s_c_gnt, s_d_gnt, s_regw;
    logic [AW-1:0] s_dr, s_sr1;

    task automatic model_eval();
        e_c = 1'b0;
        e_d = 1'b0;
        if (!RST) begin
            if (locked && d_lock)    e_d = d_req;
            else if (c_req && d_req) begin
                if (streak >= MAX_WAIT) e_d = 1'b1;
                else                    e_c = 1'b1;
            end else begin
                e_c = c_req;
                e_d = d_req;
            end
        end
        {e_regw, e_dr, e_sr1, e_sr2, e_in} = '0;
        if (e_c) begin
            e_regw = c_we && (c_wa != 0);
            {e_dr, e_sr1, e_sr2, e_in} = {c_wa, c_ra1, c_ra2, c_wd};
        end else if (e_d) begin
            e_regw = d_we && (d_wa != 0);
            {e_dr, e_sr1, e_sr2, e_in} = {d_wa, d_ra1, d_ra2, d_wd};
        end
    endtask

    task automatic model_commit();
        if (RST) begin
            streak = 0;
            locked = 1'b0;
            pc     = 1'b0;
            pd     = 1'b0;
        end else begin
            pc = e_c;
            pd = e_d;
            p1 = mem_m[e_sr1];
            p2 = mem_m[e_sr2];
            if (e_regw) mem_m[e_dr] = e_in;
            if (e_d || !d_req) streak = 0;
            else if (e_c)      streak++;
            locked = (locked && d_lock) || (e_d && d_lock);
        end
    endtask

    // One clock: inputs already set at a negedge; comb checks at +1,
    // registered checks at the following negedge.
    task automatic tick();
        #1;
        model_eval();
        s_c_gnt = c_gnt; s_d_gnt = d_gnt; s_regw = RegW; s_dr = DR; s_sr1 = SR1;
        check("c_gnt", c_gnt, e_c);
        check("d_gnt", d_gnt, e_d);
        check("gnt_excl", c_gnt & d_gnt, 0);
        check("RegW", RegW, e_regw);
        check("DR", DR, e_dr);
        check("SR1", SR1, e_sr1);
        check("SR2", SR2, e_sr2);
        check("Reg_In", Reg_In, e_in);
        @(posedge CLK);
        model_commit();
        @(negedge CLK);
        check("c_rvalid", c_rvalid, pc);
        check("d_rvalid", d_rvalid, pd);
        if (pc || pd) begin
            check("rd1", rd1, p1);
            check("rd2", rd2, p2);
        end
    endtask

    task automatic set_idle();
        {c_req, c_we, c_wa, c_ra1, c_ra2, c_wd} = '0;
        {d_req, d_we, d_wa, d_ra1, d_ra2, d_wd, d_lock} = '0;
    endtask

    typedef struct {
        logic          rst;
        logic          c_req, c_we;
        logic [AW-1:0] c_wa, c_ra1, c_ra2;
        logic [DW-1:0] c_wd;
        logic          d_req, d_we;
        logic [AW-1:0] d_wa, d_ra1, d_ra2;
        logic [DW-1:0] d_wd;
        logic          x_c, x_d, x_regw;
        logic [AW-1:0] x_dr, x_sr1, x_sr2;
        logic [DW-1:0] x_in;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            rf[i]    = 32'(32'h0101_0101 * i);
            mem_m[i] = 32'(32'h0101_0101 * i);
        end
        streak = 0; locked = 1'b0; pc = 1'b0; pd = 1'b0; p1 = '0; p2 = '0;

        tbl[0] = '{1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  32'h0,
                   1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  32'h0,
                   1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  32'h0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 5'd5,  5'd2,  5'd3,  32'hDEAD_BEEF,
                   1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  32'h0,
                   1'b1, 1'b0, 1'b1, 5'd5,  5'd2,  5'd3,  32'hDEAD_BEEF};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 5'd9,  5'd1,  5'd1,  32'h11,
                   1'b1, 1'b1, 5'd6,  5'd4,  5'd5,  32'h1234,
                   1'b0, 1'b1, 1'b1, 5'd6,  5'd4,  5'd5,  32'h1234};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 5'd0,  5'd3,  5'd4,  32'hCAFE,
                   1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  32'h0,
                   1'b1, 1'b0, 1'b0, 5'd0,  5'd3,  5'd4,  32'hCAFE};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 5'd10, 5'd11, 5'd12, 32'hAA,
                   1'b1, 1'b1, 5'd13, 5'd14, 5'd15, 32'hBB,
                   1'b1, 1'b0, 1'b0, 5'd10, 5'd11, 5'd12, 32'hAA};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 5'd10, 5'd11, 5'd12, 32'hA5,
                   1'b1, 1'b1, 5'd13, 5'd14, 5'd15, 32'hBB,
                   1'b1, 1'b0, 1'b1, 5'd10, 5'd11, 5'd12, 32'hA5};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 5'd17, 5'd18, 5'd19, 32'h5,
                   1'b0, 1'b1, 5'd20, 5'd21, 5'd22, 32'h7,
                   1'b1, 1'b0, 1'b0, 5'd17, 5'd18, 5'd19, 32'h5};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  32'h0,
                   1'b1, 1'b1, 5'd0,  5'd23, 5'd24, 32'h77,
                   1'b0, 1'b1, 1'b0, 5'd0,  5'd23, 5'd24, 32'h77};
        tbl[8] = '{1'b1, 1'b1, 1'b1, 5'd3,  5'd3,  5'd3,  32'h1,
                   1'b1, 1'b1, 5'd4,  5'd4,  5'd4,  32'h2,
                   1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  32'h0};

        set_idle();
        @(negedge CLK);
        tick();
        check("rst_c_rvalid", c_rvalid, 0);
        check("rst_d_rvalid", d_rvalid, 0);
        RST = 1'b0;

        // Vector table
        for (int i = 0; i < 9; i++) begin
            RST = tbl[i].rst;
            {c_req, c_we, c_wa, c_ra1, c_ra2, c_wd} =
                {tbl[i].c_req, tbl[i].c_we, tbl[i].c_wa, tbl[i].c_ra1, tbl[i].c_ra2, tbl[i].c_wd};
            {d_req, d_we, d_wa, d_ra1, d_ra2, d_wd} =
                {tbl[i].d_req, tbl[i].d_we, tbl[i].d_wa, tbl[i].d_ra1, tbl[i].d_ra2, tbl[i].d_wd};
            d_lock = 1'b0;
            tick();
            check("tbl_c_gnt", s_c_gnt, tbl[i].x_c);
            check("tbl_d_gnt", s_d_gnt, tbl[i].x_d);
            check("tbl_RegW", s_regw, tbl[i].x_regw);
            check("tbl_DR", s_dr, tbl[i].x_dr);
            check("tbl_SR1", s_sr1, tbl[i].x_sr1);
        end
        RST = 1'b0;
        set_idle();
        tick();

        // Core write then read back
        {c_req, c_we, c_wa, c_wd} = {1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF};
        tick();
        {c_we, c_ra1} = {1'b0, 5'd5};
        tick();
        check("t1_rvalid", c_rvalid, 1);
        check("t1_rd1", rd1, 32'hDEAD_BEEF);

        // Sustained contention: four core grants then one debug grant
        set_idle();
        tick();
        c_req = 1'b1;
        d_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t2_c_gnt", s_c_gnt, (i % 5) != 4);
            check("t2_d_gnt", s_d_gnt, (i % 5) == 4);
        end

        // Debug lock holds the core off until released
        set_idle();
        tick();
        {d_req, d_lock} = 2'b11;
        tick();
        check("t3_lock_gnt", s_d_gnt, 1);
        c_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d_req = 1'(i % 2);
            tick();
            check("t3_c_held", s_c_gnt, 0);
        end
        {d_req, d_lock} = 2'b10;
        tick();
        check("t3_release", s_c_gnt, 1);

        // R0 write is suppressed, its read proceeds
        set_idle();
        {c_req, c_we, c_wa, c_ra1, c_wd} = {1'b1, 1'b1, 5'd0, 5'd3, 32'h1357};
        tick();
        check("t4_RegW", s_regw, 0);
        check("t4_SR1", s_sr1, 3);
        check("t4_rd1", rd1, 32'h0303_0303);

        // Same-grant read returns the pre-write value
        {c_wa, c_ra1, c_wd} = {5'd7, 5'd0, 32'd1};
        tick();
        {c_wa, c_ra1, c_wd} = {5'd7, 5'd7, 32'd9};
        tick();
        check("t5_hazard", rd1, 1);
        {c_we, c_ra1} = {1'b0, 5'd7};
        tick();
        check("t5_after", rd1, 9);

        // Reset the cycle after a grant with the starve count part-way
        set_idle();
        tick();
        {c_req, d_req} = 2'b11;
        for (int i = 0; i < 3; i++) tick();
        RST = 1'b1;
        tick();
        check("t6_c_gnt", s_c_gnt, 0);
        check("t6_d_gnt", s_d_gnt, 0);
        check("t6_rvalid", c_rvalid, 0);
        RST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t6_cnt_c", s_c_gnt, i != 4);
        end
        set_idle();
        {d_req, d_lock} = 2'b11;
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        {c_req, d_req, d_lock} = 3'b101;
        tick();
        check("t6_state_arb", s_c_gnt, 1);

        // Random traffic against the model
        set_idle();
        for (int i = 0; i < 400; i++) begin
            c_req  = ($urandom % 4) != 0;
            d_req  = ($urandom % 2) != 0;
            d_lock = ($urandom % 8) == 0;
            c_we   = 1'($urandom);
            d_we   = 1'($urandom);
            c_wa   = 5'($urandom);  c_ra1 = 5'($urandom);  c_ra2 = 5'($urandom);
            d_wa   = 5'($urandom);  d_ra1 = 5'($urandom);  d_ra2 = 5'($urandom);
            c_wd   = $urandom;
            d_wd   = $urandom;
            tick();
        end
        set_idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
